// File: rtl/data_memory_responder.sv
// Data-memory responder: req/ack load/store port with configurable wait states,
// big-endian byte/halfword/word lanes, optional load sign extension and fault flagging.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rword;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_bytes [4];
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_lane_mask;
  logic [3:0]            w_be;
  logic [31:0]           w_wword;
  logic [31:0]           w_load;
  logic                  w_oor;
  logic                  w_fault;

  // In IDLE the read port follows the live address so the word is ready even with no wait states.
  assign w_idx = (r_state == S_IDLE) ? addr[ADDR_WIDTH+1:2] : r_addr[ADDR_WIDTH+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_bytes[gi] = r_rword[8*gi +: 8];
    end
  endgenerate

  // Offset 0 is the most significant lane, so the lane index is the inverted offset.
  assign w_byte = w_bytes[~r_addr[1:0]];
  assign w_half = r_addr[1] ? r_rword[15:0] : r_rword[31:16];

  assign w_oor   = (r_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_fault = (r_size == 2'd3)
                 | ((r_size == 2'd1) & r_addr[0])
                 | ((r_size == 2'd2) & (r_addr[1:0] != 2'd0))
                 | w_oor;

  always_comb begin
    w_lane_mask = 4'b0000;
    w_wword     = r_wdata;
    w_load      = r_rword;
    case (r_size)
      2'd0: begin
        w_lane_mask = 4'b1000 >> r_addr[1:0];
        w_wword     = {4{r_wdata[7:0]}};
        w_load      = {{24{r_sign & w_byte[7]}}, w_byte};
      end
      2'd1: begin
        w_lane_mask = r_addr[1] ? 4'b0011 : 4'b1100;
        w_wword     = {2{r_wdata[15:0]}};
        w_load      = {{16{r_sign & w_half[15]}}, w_half};
      end
      2'd2: begin
        w_lane_mask = 4'b1111;
      end
      default: begin
        w_lane_mask = 4'b0000;
      end
    endcase
  end

  assign w_be = (r_state == S_RESP && r_we && !w_fault) ? w_lane_mask : 4'b0000;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
    r_rword <= r_mem[w_idx];
  end

  // The access completes on the edge leaving RESP, which is the edge that raises ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_sign  <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_size  <= size;
            r_sign  <= sign;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          ack     <= 1'b1;
          err     <= w_fault;
          rdata   <= (w_fault || r_we) ? 32'd0 : w_load;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states, one with none.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [1:0]  size = 2'd0;
  logic        ack, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0, sign0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [1:0]  size0 = 2'd0;
  logic        ack0, err0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign(sign), .ack(ack), .rdata(rdata), .err(err)
  );

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .size(size0), .sign(sign0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; optionally moves addr during the wait states.
  task automatic xfer(input string tag, input logic t_we, input logic [31:0] t_addr,
                      input logic [31:0] t_wdata, input logic [1:0] t_size, input logic t_sign,
                      input logic chg, input logic [31:0] chg_addr,
                      output logic [31:0] o_rd, output logic o_err, output int o_lat);
    int   n;
    logic seen;
    @(negedge clk);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; size = t_size; sign = t_sign;
    @(posedge clk);
    #1;
    if (chg) addr = chg_addr;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      seen = ack;
    end
    o_rd = rdata; o_err = err; o_lat = n;
    req = 1'b0;
    check({tag, "_ack"}, 32'(seen), 32'd1);
    $display("txn %s we=%0d addr=%h wdata=%h size=%0d sign=%0d -> rdata=%h err=%0d lat=%0d",
             tag, t_we, t_addr, t_wdata, t_size, t_sign, o_rd, o_err, o_lat);
    @(posedge clk);
    #1;
    check({tag, "_after"}, rdata | {30'd0, ack, err}, 32'd0);
  endtask

  task automatic xfer0(input string tag, input logic t_we, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input logic [1:0] t_size, input logic t_sign,
                       output logic [31:0] o_rd, output logic o_err, output int o_lat);
    int   n;
    logic seen;
    @(negedge clk);
    req0 = 1'b1; we0 = t_we; addr0 = t_addr; wdata0 = t_wdata; size0 = t_size; sign0 = t_sign;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      seen = ack0;
    end
    o_rd = rdata0; o_err = err0; o_lat = n;
    req0 = 1'b0;
    check({tag, "_ack"}, 32'(seen), 32'd1);
    $display("txn %s we=%0d addr=%h wdata=%h size=%0d sign=%0d -> rdata=%h err=%0d lat=%0d",
             tag, t_we, t_addr, t_wdata, t_size, t_sign, o_rd, o_err, o_lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          acks [3];
  int          na, cyc;
  logic        seen_ack;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Word round trip
    xfer("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("st_w10_lat", 32'(lat), 32'd3);
    check("st_w10_rd", rd, 32'd0);
    check("st_w10_err", 32'(er), 32'd0);
    xfer("ld_w10", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_w10_lat", 32'(lat), 32'd3);
    check("ld_w10_rd", rd, 32'hDEADBEEF);
    check("ld_w10_err", 32'(er), 32'd0);

    // Lanes and extension
    xfer("st_w20", 1'b1, 32'h20, 32'h80F17F02, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    xfer("ld_b20s", 1'b0, 32'h20, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, rd, er, lat);
    check("ld_b20s_rd", rd, 32'hFFFFFF80);
    xfer("ld_b21u", 1'b0, 32'h21, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_b21u_rd", rd, 32'h000000F1);
    xfer("ld_b22s", 1'b0, 32'h22, 32'd0, 2'd0, 1'b1, 1'b0, 32'd0, rd, er, lat);
    check("ld_b22s_rd", rd, 32'h0000007F);
    xfer("ld_h20u", 1'b0, 32'h20, 32'd0, 2'd1, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_h20u_rd", rd, 32'h000080F1);
    xfer("ld_h20s", 1'b0, 32'h20, 32'd0, 2'd1, 1'b1, 1'b0, 32'd0, rd, er, lat);
    check("ld_h20s_rd", rd, 32'hFFFF80F1);
    xfer("ld_h22s", 1'b0, 32'h22, 32'd0, 2'd1, 1'b1, 1'b0, 32'd0, rd, er, lat);
    check("ld_h22s_rd", rd, 32'h00007F02);
    xfer("st_b23", 1'b1, 32'h23, 32'h123456AA, 2'd0, 1'b0, 1'b0, 32'd0, rd, er, lat);
    xfer("ld_w20", 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_w20_rd", rd, 32'h80F17FAA);
    xfer("st_h20", 1'b1, 32'h20, 32'hFFFF1234, 2'd1, 1'b0, 1'b0, 32'd0, rd, er, lat);
    xfer("ld_w20b", 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_w20b_rd", rd, 32'h12347FAA);

    // Faults
    xfer("ld_h21", 1'b0, 32'h21, 32'd0, 2'd1, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_h21_err", 32'(er), 32'd1);
    check("ld_h21_rd", rd, 32'd0);
    xfer("st_w24", 1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    xfer("st_w26", 1'b1, 32'h26, 32'h12345678, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("st_w26_err", 32'(er), 32'd1);
    xfer("ld_w24", 1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_w24_rd", rd, 32'hCAFEF00D);
    check("ld_w24_err", 32'(er), 32'd0);
    xfer("ld_s3", 1'b0, 32'h24, 32'd0, 2'd3, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_s3_err", 32'(er), 32'd1);
    check("ld_s3_rd", rd, 32'd0);
    xfer("ld_oor", 1'b0, 32'h1000, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_oor_err", 32'(er), 32'd1);
    check("ld_oor_rd", rd, 32'd0);
    xfer("ld_last", 1'b0, 32'hFFC, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_last_err", 32'(er), 32'd0);

    // Address moved during wait states
    xfer("ld_chg", 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, 32'h20, rd, er, lat);
    check("ld_chg_rd", rd, 32'hDEADBEEF);

    // req held high: back-to-back accesses every WAIT_CYCLES+2 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'd2; sign = 1'b0;
    na = 0;
    cyc = 0;
    while (na < 3 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (ack) begin
        acks[na] = cyc;
        check("b2b_rd", rdata, 32'hDEADBEEF);
        $display("txn b2b ack=%0d cycle=%0d rdata=%h", na, cyc, rdata);
        na++;
        if (na == 3) req = 1'b0;
      end
    end
    req = 1'b0;
    check("b2b_count", 32'(na), 32'd3);
    check("b2b_first", 32'(acks[0]), 32'd4);
    check("b2b_gap1", 32'(acks[1] - acks[0]), 32'd4);
    check("b2b_gap2", 32'(acks[2] - acks[1]), 32'd4);
    @(posedge clk);

    // Reset during the wait states of a store
    xfer("st_w40", 1'b1, 32'h40, 32'h11111111, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h55555555; size = 2'd2; sign = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("mid_rst_out", rdata | {30'd0, ack, err}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_out2", rdata | {30'd0, ack, err}, 32'd0);
    rst = 1'b0;
    seen_ack = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen_ack = seen_ack | ack;
    end
    $display("txn st_w40_aborted ack_seen=%0d", seen_ack);
    check("mid_rst_noack", 32'(seen_ack), 32'd0);
    xfer("ld_w40", 1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0, rd, er, lat);
    check("ld_w40_rd", rd, 32'h11111111);

    // Zero wait states
    xfer0("z_st_w8", 1'b1, 32'h8, 32'hA5A50F0F, 2'd2, 1'b0, rd, er, lat);
    check("z_st_w8_lat", 32'(lat), 32'd1);
    xfer0("z_ld_w8", 1'b0, 32'h8, 32'd0, 2'd2, 1'b0, rd, er, lat);
    check("z_ld_w8_lat", 32'(lat), 32'd1);
    check("z_ld_w8_rd", rd, 32'hA5A50F0F);
    xfer0("z_ld_h8s", 1'b0, 32'h8, 32'd0, 2'd1, 1'b1, rd, er, lat);
    check("z_ld_h8s_rd", rd, 32'hFFFFA5A5);
    xfer0("z_ld_b9u", 1'b0, 32'h9, 32'd0, 2'd0, 1'b0, rd, er, lat);
    check("z_ld_b9u_rd", rd, 32'h000000A5);
    xfer0("z_ld_w9", 1'b0, 32'h9, 32'd0, 2'd2, 1'b0, rd, er, lat);
    check("z_ld_w9_err", 32'(er), 32'd1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
